// File: rtl/fml_arb2_pkg.sv
// fml_arb2_pkg: shared FSM encodings and constants for the two-master FML arbiter
package fml_arb2_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, BURST = 2'd2} state_t;
    localparam int BURST_LEN_DEF = 8;
    localparam int FML_DW = 16;
endpackage

// File: rtl/fml_arb2.sv
// fml_arb2: arbitrates two FML masters onto one FML slave, round-robin by default.
// Define FML_ARB2_FIXED_PRIO_EN to give m0 fixed priority on simultaneous requests.
module fml_arb2
    import fml_arb2_pkg::*;
#(
    parameter int fml_depth = 23,
    parameter int burst_len = BURST_LEN_DEF
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [fml_depth-1:0] m0_adr,
    input  logic                 m0_stb,
    input  logic                 m0_we,
    input  logic [1:0]           m0_sel,
    input  logic [FML_DW-1:0]    m0_do,
    output logic                 m0_ack,
    output logic [FML_DW-1:0]    m0_di,
    input  logic [fml_depth-1:0] m1_adr,
    input  logic                 m1_stb,
    input  logic                 m1_we,
    input  logic [1:0]           m1_sel,
    input  logic [FML_DW-1:0]    m1_do,
    output logic                 m1_ack,
    output logic [FML_DW-1:0]    m1_di,
    output logic [fml_depth-1:0] s_adr,
    output logic                 s_stb,
    output logic                 s_we,
    output logic [1:0]           s_sel,
    output logic [FML_DW-1:0]    s_do,
    input  logic                 s_ack,
    input  logic [FML_DW-1:0]    s_di
);
    localparam int CW = burst_len > 1 ? $clog2(burst_len) : 1;
    localparam logic [CW-1:0] LAST = CW'(burst_len - 1);
    state_t state, state_n;
    logic owner, owner_n, win, busy, own_stb, hit;
    logic [CW-1:0] cnt, cnt_n;
`ifdef FML_ARB2_FIXED_PRIO_EN
    assign win = ~m0_stb;
`else
    logic last_served;
    assign win = (m0_stb & m1_stb) ? ~last_served : m1_stb;
    always_ff @(posedge sys_clk or posedge sys_rst)
        if (sys_rst) last_served <= 1'b1;
        else if (hit) last_served <= owner;
`endif
    assign busy    = state != IDLE;
    assign own_stb = owner ? m1_stb : m0_stb;
    assign s_stb   = (state == REQ) & own_stb;
    assign hit     = s_stb & s_ack;
    assign m0_ack  = hit & ~owner;
    assign m1_ack  = hit & owner;
    assign s_adr   = busy ? (owner ? m1_adr : m0_adr) : '0;
    assign s_we    = busy & (owner ? m1_we : m0_we);
    assign s_sel   = busy ? (owner ? m1_sel : m0_sel) : 2'b00;
    assign s_do    = busy ? (owner ? m1_do : m0_do) : '0;
    assign m0_di   = s_di;
    assign m1_di   = s_di;
    always_ff @(posedge sys_clk or posedge sys_rst)
        if (sys_rst) begin
            state <= IDLE;
            owner <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            cnt   <= cnt_n;
        end
    always_comb begin
        state_n = state;
        owner_n = owner;
        cnt_n   = cnt;
        case (state)
            IDLE: if (m0_stb | m1_stb) begin
                owner_n = win;
                state_n = REQ;
            end
            REQ: if (!own_stb) state_n = IDLE;
                else if (s_ack) begin
                    cnt_n   = '0;
                    state_n = BURST;
                end
            BURST: begin
                cnt_n   = cnt + 1'b1;
                state_n = cnt == LAST ? IDLE : BURST;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
